// File: rtl/prog_instruction_memory.sv
// rtl/prog_instruction_memory.sv - run-time loadable instruction store with registered one-cycle fetch
// Optional boot program writer enabled by defining IMEM_BOOT_PROGRAM_EN.
module prog_instruction_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instrValid,
    output logic                  fetchFault,
    input  logic                  loadStart,
    input  logic [ADDR_WIDTH-1:0] loadBase,
    input  logic                  loadValid,
    input  logic [DATA_WIDTH-1:0] loadData,
    input  logic                  loadLast,
    output logic                  loadReady,
    output logic                  busy,
    output logic                  loadOverflow
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_LOAD} state_t;

`ifdef IMEM_BOOT_PROGRAM_EN
    localparam state_t C_RESET_STATE = S_BOOT;
`else
    localparam state_t C_RESET_STATE = S_RUN;
`endif

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH:0]   r_ptr, w_ptr_next;
    logic                  r_load_ready, w_load_ready_next;
    logic                  r_overflow, w_overflow_next;
    logic [DATA_WIDTH-1:0] r_instruction;
    logic                  r_instr_valid;
    logic                  r_fetch_fault;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_we;
    logic [MEM_AW-1:0]     w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_xfer;
    logic                  w_base_in_range;
    logic                  w_fetch_in_range;
    logic [ADDR_WIDTH:0]   w_base_ext;

    assign w_base_ext       = {1'b0, loadBase};
    assign w_base_in_range  = w_base_ext < C_DEPTH;
    assign w_fetch_in_range = {1'b0, fetchAddress} < C_DEPTH;
    assign w_xfer           = (r_state == S_LOAD) && loadValid && r_load_ready;

`ifdef IMEM_BOOT_PROGRAM_EN
    logic [2:0] r_boot_idx, w_boot_idx_next;
    logic [7:0] w_boot_byte;

    always_comb begin
        case (r_boot_idx)
            3'd0:    w_boot_byte = 8'h44;
            3'd1:    w_boot_byte = 8'h49;
            3'd2:    w_boot_byte = 8'h18;
            3'd3:    w_boot_byte = 8'h89;
            default: w_boot_byte = 8'hC3;
        endcase
    end
`endif

    always_comb begin
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_load_ready_next = r_load_ready;
        w_overflow_next   = r_overflow;
        w_we              = 1'b0;
        w_waddr           = r_ptr[MEM_AW-1:0];
        w_wdata           = loadData;
`ifdef IMEM_BOOT_PROGRAM_EN
        w_boot_idx_next   = r_boot_idx;
`endif
        case (r_state)
`ifdef IMEM_BOOT_PROGRAM_EN
            S_BOOT: begin
                // Boot addresses beyond a small DEPTH are skipped, not wrapped.
                w_we            = (32'(r_boot_idx) < DEPTH);
                w_waddr         = MEM_AW'(r_boot_idx);
                w_wdata         = DATA_WIDTH'(w_boot_byte);
                w_boot_idx_next = r_boot_idx + 3'd1;
                if (r_boot_idx == 3'd4) begin
                    w_state_next = S_RUN;
                end
            end
`endif
            S_RUN: begin
                if (loadStart) begin
                    w_state_next      = S_LOAD;
                    w_ptr_next        = w_base_ext;
                    w_load_ready_next = w_base_in_range;
                    w_overflow_next   = !w_base_in_range;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_we = 1'b1;
                    if (loadLast) begin
                        w_state_next      = S_RUN;
                        w_load_ready_next = 1'b0;
                    end else begin
                        w_ptr_next = r_ptr + 1'b1;
                        if (r_ptr == C_LAST) begin
                            w_overflow_next   = 1'b1;
                            w_load_ready_next = 1'b0;
                        end
                    end
                end else if (r_overflow && loadValid && loadLast) begin
                    w_state_next      = S_RUN;
                    w_load_ready_next = 1'b0;
                end
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state      <= C_RESET_STATE;
            r_ptr        <= '0;
            r_load_ready <= 1'b0;
            r_overflow   <= 1'b0;
`ifdef IMEM_BOOT_PROGRAM_EN
            r_boot_idx   <= 3'd0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_load_ready <= w_load_ready_next;
            r_overflow   <= w_overflow_next;
`ifdef IMEM_BOOT_PROGRAM_EN
            r_boot_idx   <= w_boot_idx_next;
`endif
        end
    end

    // Storage is never reset; a reset edge only suppresses the write in flight.
    always_ff @(posedge clk) begin
        if (resetN && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            if ((r_state == S_RUN) && fetchReq) begin
                r_instr_valid <= 1'b1;
                if (w_fetch_in_range) begin
                    r_instruction <= r_mem[fetchAddress[MEM_AW-1:0]];
                end else begin
                    r_instruction <= '0;
                    r_fetch_fault <= 1'b1;
                end
            end
        end
    end

    assign instruction  = r_instruction;
    assign instrValid   = r_instr_valid;
    assign fetchFault   = r_fetch_fault;
    assign loadReady    = r_load_ready;
    assign loadOverflow = r_overflow;
    assign busy         = (r_state != S_RUN);

endmodule

// File: tb/tb_prog_instruction_memory.sv
// tb/tb_prog_instruction_memory.sv - randomized self-checking bench for prog_instruction_memory (DEPTH=16)
module tb_prog_instruction_memory;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
`ifdef IMEM_BOOT_PROGRAM_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic          fetchReq;
    logic [AW-1:0] fetchAddress;
    logic [DW-1:0] instruction;
    logic          instrValid;
    logic          fetchFault;
    logic          loadStart;
    logic [AW-1:0] loadBase;
    logic          loadValid;
    logic [DW-1:0] loadData;
    logic          loadLast;
    logic          loadReady;
    logic          busy;
    logic          loadOverflow;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [DEPTH];
    bit            model_known [DEPTH];
    logic [DW-1:0] ld_data [64];
    int            fa [64];

    always #5 clk = ~clk;

    prog_instruction_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .fetchReq    (fetchReq),
        .fetchAddress(fetchAddress),
        .instruction (instruction),
        .instrValid  (instrValid),
        .fetchFault  (fetchFault),
        .loadStart   (loadStart),
        .loadBase    (loadBase),
        .loadValid   (loadValid),
        .loadData    (loadData),
        .loadLast    (loadLast),
        .loadReady   (loadReady),
        .busy        (busy),
        .loadOverflow(loadOverflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_reset();
        int n;
        logic [7:0] boot_vals [5];
        boot_vals = '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3};
        resetN = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== (BOOT_EN ? 5 : 0)) begin
            errors++;
            $display("FAIL boot_cycles: got %0d required %0d", n, BOOT_EN ? 5 : 0);
        end
        if (BOOT_EN) begin
            for (int k = 0; k < 5; k++) begin
                model_mem[k]   = DW'(boot_vals[k]);
                model_known[k] = 1'b1;
            end
        end
    endtask

    task automatic fetch_burst(input int cnt, input string tag);
        logic [DW-1:0] exp_instr;
        bit            exp_known;
        exp_instr = '0;
        exp_known = 1'b0;
        for (int j = 0; j < cnt; j++) begin
            fetchReq     = 1'b1;
            fetchAddress = AW'(fa[j]);
            tick();
            if (fa[j] >= DEPTH) begin
                exp_instr = '0;
                exp_known = 1'b1;
            end else begin
                exp_instr = model_mem[fa[j]];
                exp_known = model_known[fa[j]];
            end
            checks++;
            if (instrValid !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid addr=%0d: got %b required 1", tag, fa[j], instrValid);
            end
            checks++;
            if (fetchFault !== (fa[j] >= DEPTH)) begin
                errors++;
                $display("FAIL %s_fault addr=%0d: got %b required %b", tag, fa[j], fetchFault, fa[j] >= DEPTH);
            end
            if (exp_known) begin
                checks++;
                if (instruction !== exp_instr) begin
                    errors++;
                    $display("FAIL %s_data addr=%0d: got %h required %h", tag, fa[j], instruction, exp_instr);
                end
            end
        end
        fetchReq = 1'b0;
        tick();
        checks++;
        if (instrValid !== 1'b0 || fetchFault !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got valid=%b fault=%b required 0 0", tag, instrValid, fetchFault);
        end
        if (exp_known) begin
            checks++;
            if (instruction !== exp_instr) begin
                errors++;
                $display("FAIL %s_hold: got %h required %h", tag, instruction, exp_instr);
            end
        end
    endtask

    task automatic run_load(input int base, input int n, input string tag);
        int c;
        int budget;
        bit accept;
        loadStart = 1'b1;
        loadBase  = AW'(base);
        tick();
        loadStart = 1'b0;
        c = 0;
        budget = 0;
        while (c < n && budget < 4 * DEPTH + 8) begin
            checks++;
            if (loadReady !== (base + c < DEPTH)) begin
                errors++;
                $display("FAIL %s_ready c=%0d: got %b required %b", tag, c, loadReady, base + c < DEPTH);
            end
            checks++;
            if (loadOverflow !== (base + c >= DEPTH)) begin
                errors++;
                $display("FAIL %s_ovf c=%0d: got %b required %b", tag, c, loadOverflow, base + c >= DEPTH);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy c=%0d: got %b required 1", tag, c, busy);
            end
            loadValid = 1'b1;
            loadData  = ld_data[c];
            loadLast  = (c == n - 1);
            accept    = loadReady || loadOverflow;
            tick();
            if (accept) begin
                if (base + c < DEPTH) begin
                    model_mem[base + c]   = ld_data[c];
                    model_known[base + c] = 1'b1;
                end
                c++;
            end
            budget++;
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
        checks++;
        if (c < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words required %0d", tag, c, n);
        end
        checks++;
        if (busy !== 1'b0 || loadReady !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: got busy=%b ready=%b required 0 0", tag, busy, loadReady);
        end
        checks++;
        if (loadOverflow !== (base + n > DEPTH)) begin
            errors++;
            $display("FAIL %s_ovf_end: got %b required %b", tag, loadOverflow, base + n > DEPTH);
        end
    endtask

    task automatic test_reset();
        resetN       = 1'b0;
        fetchReq     = 1'b1;
        fetchAddress = 8'd3;
        loadStart    = 1'b1;
        loadBase     = 8'd0;
        loadValid    = 1'b1;
        loadData     = 8'hEE;
        loadLast     = 1'b0;
        tick();
        tick();
        checks++;
        if (instruction !== '0 || instrValid !== 1'b0 || fetchFault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch: got instr=%h valid=%b fault=%b required 0 0 0", instruction, instrValid, fetchFault);
        end
        checks++;
        if (loadReady !== 1'b0 || loadOverflow !== 1'b0 || busy !== BOOT_EN) begin
            errors++;
            $display("FAIL reset_load: got ready=%b ovf=%b busy=%b required 0 0 %b", loadReady, loadOverflow, busy, BOOT_EN);
        end
        fetchReq  = 1'b0;
        loadStart = 1'b0;
        loadValid = 1'b0;
        finish_reset();
    endtask

    task automatic test_boot();
        for (int k = 0; k < 5; k++) fa[k] = k;
        fetch_burst(5, "boot");
    endtask

    task automatic test_load_readback();
        for (int i = 0; i < DEPTH; i++) ld_data[i] = DW'($urandom);
        run_load(0, DEPTH, "fill");
        ld_data[0] = 8'hA1;
        ld_data[1] = 8'hA2;
        ld_data[2] = 8'hA3;
        run_load(5, 3, "ld3");
        for (int k = 0; k < DEPTH; k++) fa[k] = k;
        fetch_burst(DEPTH, "readback");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) ld_data[i] = 8'hB0 + DW'(i);
        run_load(14, 4, "ovf");
        fa[0] = 13;
        fa[1] = 14;
        fa[2] = 15;
        fetch_burst(3, "ovf_rd");
        ld_data[0] = 8'h5A;
        run_load(20, 1, "ovf_base");
    endtask

    task automatic test_fault();
        fa[0] = 20;
        fa[1] = 16;
        fa[2] = 15;
        fa[3] = 255;
        for (int k = 4; k < 10; k++) fa[k] = $urandom_range(0, 255);
        fetch_burst(10, "fault");
    endtask

    task automatic test_collision();
        logic [DW-1:0] w;
        w = DW'($urandom);
        fetchReq     = 1'b1;
        fetchAddress = 8'd3;
        loadStart    = 1'b1;
        loadBase     = 8'd0;
        tick();
        loadStart = 1'b0;
        checks++;
        if (instrValid !== 1'b1 || instruction !== model_mem[3]) begin
            errors++;
            $display("FAIL coll_fetch: got valid=%b instr=%h required 1 %h", instrValid, instruction, model_mem[3]);
        end
        checks++;
        if (busy !== 1'b1 || loadReady !== 1'b1) begin
            errors++;
            $display("FAIL coll_enter: got busy=%b ready=%b required 1 1", busy, loadReady);
        end
        fetchAddress = 8'd4;
        loadStart    = 1'b1;
        loadBase     = 8'd9;
        tick();
        checks++;
        if (instrValid !== 1'b0) begin
            errors++;
            $display("FAIL coll_load_fetch: got valid=%b required 0", instrValid);
        end
        fetchReq  = 1'b0;
        loadStart = 1'b0;
        loadValid = 1'b1;
        loadData  = w;
        loadLast  = 1'b1;
        tick();
        loadValid = 1'b0;
        loadLast  = 1'b0;
        model_mem[0] = w;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_exit: got busy=%b required 0", busy);
        end
        fa[0] = 0;
        fa[1] = 9;
        fetch_burst(2, "coll_rd");
    endtask

    task automatic test_random();
        int base;
        int n;
        for (int it = 0; it < 20; it++) begin
            base = $urandom_range(0, DEPTH + 3);
            n    = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) ld_data[i] = DW'($urandom);
            run_load(base, n, "rnd");
            for (int k = 0; k < 6; k++) fa[k] = $urandom_range(0, DEPTH + 7);
            fetch_burst(6, "rnd_rd");
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 5; i++) ld_data[i] = 8'hC0 + DW'(i);
        loadStart = 1'b1;
        loadBase  = 8'd8;
        tick();
        loadStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            loadValid = 1'b1;
            loadData  = ld_data[i];
            loadLast  = 1'b0;
            tick();
            model_mem[8 + i] = ld_data[i];
        end
        loadValid = 1'b0;
        resetN    = 1'b0;
        tick();
        checks++;
        if (busy !== BOOT_EN || loadReady !== 1'b0 || loadOverflow !== 1'b0 || instrValid !== 1'b0 || instruction !== '0) begin
            errors++;
            $display("FAIL midreset_out: got busy=%b ready=%b ovf=%b valid=%b instr=%h required %b 0 0 0 00",
                     busy, loadReady, loadOverflow, instrValid, instruction, BOOT_EN);
        end
        finish_reset();
        fa[0] = 8;
        fa[1] = 9;
        fa[2] = 10;
        fa[3] = 0;
        fetch_burst(4, "midreset_rd");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            model_mem[k]   = '0;
            model_known[k] = 1'b0;
        end
        test_reset();
`ifdef IMEM_BOOT_PROGRAM_EN
        test_boot();
`endif
        test_load_readback();
        test_overflow();
        test_fault();
        test_collision();
        test_random();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prog_instruction_memory.md
# prog_instruction_memory

Parametrised, run-time loadable instruction store for the 8-bit microprocessor. It sits between the program counter and the decoder and returns one instruction word per fetch with a registered, one-cycle read. It also accepts a new program over a valid/ready byte-stream loader, so programs no longer have to be hard-wired into the netlist. An optional boot sequencer writes the default 5-instruction program after reset.

## Interface
- DATA_WIDTH, 8, instruction word width; must be at least 8 when the boot program is compiled in.
- ADDR_WIDTH, 8, width of fetch and load addresses.
- DEPTH, 256, number of words; must be between 1 and 2^ADDR_WIDTH.
- clk  in  1  single clock; all logic on the rising edge.
- resetN  in  1  synchronous, active-low reset.
- fetchReq  in  1  fetch strobe.
- fetchAddress  in  ADDR_WIDTH  fetch word address.
- instruction  out  DATA_WIDTH  registered fetch result.
- instrValid  out  1  one-cycle pulse qualifying `instruction`.
- fetchFault  out  1  pulse with instrValid when fetchAddress ≥ DEPTH.
- loadStart  in  1  begin a load session (sampled only in RUN).
- loadBase  in  ADDR_WIDTH  first write address, sampled with loadStart.
- loadValid  in  1  loader data valid.
- loadData  in  DATA_WIDTH  word to write.
- loadLast  in  1  marks the final word of the session.
- loadReady  out  1  block can accept a load word.
- busy  out  1  high in BOOT or LOAD; fetches are not served.
- loadOverflow  out  1  sticky: the session ran past DEPTH-1.

## Operation
- States: BOOT (only when compiled in), RUN, LOAD.
- Reset values of all outputs: instruction=0, instrValid=0, fetchFault=0, loadReady=0, loadOverflow=0.
  - busy=1 if BOOT is compiled in, else 0.
  - Memory contents are not reset.
- RUN, fetch behaviour:
  - fetchReq=1 with fetchAddress < DEPTH: next cycle instruction=mem[fetchAddress], instrValid=1.
  - fetchAddress ≥ DEPTH: next cycle instruction=0, instrValid=1, fetchFault=1.
  - No fetchReq: instrValid=0 and instruction holds its last value.
- RUN, load entry:
  - loadStart=1 latches pointer=loadBase and clears loadOverflow; the next state is LOAD.
  - A fetchReq in the same cycle is still served.
- LOAD:
  - busy=1. fetchReq is ignored (no instrValid). loadStart is ignored.
  - loadReady=1 while pointer < DEPTH and loadOverflow=0.
  - Transfer happens when loadValid && loadReady: mem[pointer]=loadData, pointer increments.
  - Transfer with loadLast=1: return to RUN next cycle, loadReady=0.
  - A non-last transfer to address DEPTH-1, or a loadBase ≥ DEPTH: loadOverflow=1, loadReady=0.
  - While overflowed, words offered are dropped. loadValid&&loadLast returns the block to RUN. loadOverflow stays set until the next loadStart.
- Pointer width is ADDR_WIDTH+1, so it never wraps; there is no wrap-around into low addresses.
- Reset in the middle of LOAD or BOOT aborts the session. Words already written are retained and loadOverflow clears.

## Timing
- Fetch latency is 1 cycle (request at edge N, data and instrValid after edge N+1). Back-to-back fetches give one result per cycle.
- Load throughput is 1 word per cycle. loadReady is registered and does not depend combinationally on loadValid.
- RUN→LOAD: loadReady rises the cycle after loadStart.
- LOAD→RUN: a fetch is accepted the cycle after the last transfer. It returns the newly written data, because the write completes before the read.

## Configuration
- Macro `IMEM_BOOT_PROGRAM_EN`.
- Defined:
  - After resetN is released, BOOT writes 0x44, 0x49, 0x18, 0x89, 0xC3 (zero-extended to DATA_WIDTH) to addresses 0..4, one word per cycle over 5 cycles. Addresses ≥ DEPTH are skipped.
  - busy=1 throughout, loadStart is ignored, then the block enters RUN.
  - Reset during BOOT restarts BOOT.
- Undefined: reset goes directly to RUN, and memory is undefined until loaded.

## Test plan
- Boot (macro on): release reset, wait until busy=0, fetch addresses 0..4 back-to-back -> instruction 0x44, 0x49, 0x18, 0x89, 0xC3 on consecutive cycles, each with instrValid=1.
- Load/readback: loadStart with loadBase=0x10, stream 0xA1, 0xA2, 0xA3 with loadLast on 0xA3 -> busy falls; fetches of 0x10..0x12 return 0xA1..0xA3; loadOverflow=0.
- Overflow (DEPTH=16): loadBase=14, stream 4 words with loadLast on the 4th -> addresses 14 and 15 written; loadReady drops after the 2nd transfer; loadOverflow=1; RUN is re-entered only after loadValid&&loadLast.
- Fault (DEPTH=16): fetch address 20 -> instruction=0, instrValid=1, fetchFault=1 for one cycle.
- Collision: fetchReq(addr 3) together with loadStart -> fetch result still returned next cycle; a fetchReq during LOAD produces no instrValid.
- Reset mid-load: assert resetN=0 after 2 of 5 words -> outputs reset; the 2 written words read back; loadOverflow=0.
